// File: rtl/dual_port_ram_param.sv
// Parametrised simple dual-port RAM: one write port, one registered read port,
// selectable read-during-write behaviour, and a self-running init sweep that
// loads INIT_VALUE into every word after reset or on a clear request.
module dual_port_ram_param #(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter int unsigned            ADDR_WIDTH = 4,
  parameter int unsigned            DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0,
  parameter int unsigned            RD_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  rd_valid,
  output logic                  busy
);

  // Storage index width; a single-word array still needs a 1-bit index.
  localparam int unsigned          MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]  DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // Reject impossible geometries at elaboration.
  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("dual_port_ram_param: DEPTH must be in 1..2**ADDR_WIDTH");
  end

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   d_out_q, d_out_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    busy_q, busy_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we_c;
  logic [MEM_AW-1:0]       mem_waddr_c;
  logic [DATA_WIDTH-1:0]   mem_wdata_c;
  logic                    wr_in_range_c;
  logic                    rd_in_range_c;
  logic                    collide_c;

  // Address range qualification and same-address collision detect.
  assign wr_in_range_c = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_in_range_c = ({1'b0, rd_addr} < DEPTH_EXT);
  assign collide_c     = we && (wr_addr == rd_addr);

  // Next-state, write-port steering and read-data selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_out_d     = d_out_q;
    rd_valid_d  = 1'b0;
    busy_d      = busy_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = MEM_AW'(cnt_q);
    mem_wdata_c = INIT_VALUE;

    case (state_q)
      ST_INIT: begin
        mem_we_c = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (clear) begin
          // Clear takes priority; any same-cycle access is dropped.
          state_d = ST_INIT;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          if (we && wr_in_range_c) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = MEM_AW'(wr_addr);
            mem_wdata_c = d_in;
          end
          if (re) begin
            rd_valid_d = 1'b1;
            if (!rd_in_range_c) begin
              d_out_d = '0;
            end else if (RD_MODE == 0 && collide_c) begin
              d_out_d = d_in;
            end else begin
              d_out_d = mem_q[MEM_AW'(rd_addr)];
            end
          end
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Control and output registers; array contents are not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      d_out_q    <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_out_q    <= d_out_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign d_out    = d_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench for dual_port_ram_param: three instances (write-first/INIT 5A,
// read-first/INIT 00, DEPTH 12) share one stimulus stream; an array-based
// model of each is checked every cycle, plus literal spot checks.
module tb_dual_port_ram_param;

  localparam int NI = 3;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       we;
  logic       re;
  logic [3:0] wr_addr;
  logic [3:0] rd_addr;
  logic [7:0] d_in;

  logic [7:0] dut_dout [NI];
  logic       dut_rv   [NI];
  logic       dut_busy [NI];

  int n_checks = 0;
  int n_pass   = 0;

  dual_port_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16),
                        .INIT_VALUE(8'h5A), .RD_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .we(we), .wr_addr(wr_addr),
    .d_in(d_in), .re(re), .rd_addr(rd_addr), .d_out(dut_dout[0]),
    .rd_valid(dut_rv[0]), .busy(dut_busy[0]));

  dual_port_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16),
                        .INIT_VALUE(8'h00), .RD_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .we(we), .wr_addr(wr_addr),
    .d_in(d_in), .re(re), .rd_addr(rd_addr), .d_out(dut_dout[1]),
    .rd_valid(dut_rv[1]), .busy(dut_busy[1]));

  dual_port_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12),
                        .INIT_VALUE(8'h00), .RD_MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .we(we), .wr_addr(wr_addr),
    .d_in(d_in), .re(re), .rd_addr(rd_addr), .d_out(dut_dout[2]),
    .rd_valid(dut_rv[2]), .busy(dut_busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep_of(int i);
    return (i == 2) ? 12 : 16;
  endfunction

  function automatic logic [7:0] init_of(int i);
    return (i == 0) ? 8'h5A : 8'h00;
  endfunction

  function automatic int mode_of(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: words still to sweep, memory image, output state.
  logic [7:0] m_mem  [NI][16];
  int         m_left [NI];
  logic [7:0] m_dout [NI];
  logic       m_rv   [NI];

  task automatic model_step(int i);
    int dep;
    dep = dep_of(i);
    if (m_left[i] > 0) begin
      m_mem[i][dep - m_left[i]] = init_of(i);
      m_left[i]--;
      m_rv[i] = 1'b0;
    end else if (clear) begin
      m_left[i] = dep;
      m_rv[i]   = 1'b0;
    end else begin
      if (re) begin
        m_rv[i] = 1'b1;
        if (int'(rd_addr) >= dep) m_dout[i] = 8'h00;
        else if (mode_of(i) == 0 && we && wr_addr == rd_addr) m_dout[i] = d_in;
        else m_dout[i] = m_mem[i][rd_addr];
      end else begin
        m_rv[i] = 1'b0;
      end
      if (we && int'(wr_addr) < dep) m_mem[i][wr_addr] = d_in;
    end
  endtask

  // Model update on each edge / reset, then compare shortly after.
  initial begin
    for (int i = 0; i < NI; i++) begin
      m_left[i] = dep_of(i);
      m_dout[i] = 8'h00;
      m_rv[i]   = 1'b0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          m_left[i] = dep_of(i);
          m_dout[i] = 8'h00;
          m_rv[i]   = 1'b0;
        end else begin
          model_step(i);
        end
      end
      #1;
      for (int i = 0; i < NI; i++) begin
        check($sformatf("u%0d_busy", i), 32'(dut_busy[i]), 32'(m_left[i] > 0));
        check($sformatf("u%0d_rd_valid", i), 32'(dut_rv[i]), 32'(m_rv[i]));
        check($sformatf("u%0d_d_out", i), 32'(dut_dout[i]), 32'(m_dout[i]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; wr_addr = a; d_in = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    re = 1'b1; rd_addr = a;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus with literal expectations.
  initial begin
    int nb;
    rst_n = 1'b0; clear = 1'b0; we = 1'b0; re = 1'b0;
    wr_addr = '0; rd_addr = '0; d_in = '0;
    repeat (3) tick();
    check("rst_busy", 32'(dut_busy[0]), 32'd1);
    check("rst_rd_valid", 32'(dut_rv[0]), 32'd0);
    check("rst_d_out", 32'(dut_dout[0]), 32'h00);
    rst_n = 1'b1;

    // Initial sweep: DEPTH 12 finishes at edge 12, DEPTH 16 at edge 16.
    repeat (11) tick();
    check("d12_busy_edge11", 32'(dut_busy[2]), 32'd1);
    tick();
    check("d12_busy_edge12", 32'(dut_busy[2]), 32'd0);
    repeat (3) tick();
    check("busy_edge15", 32'(dut_busy[0]), 32'd1);
    tick();
    check("busy_edge16", 32'(dut_busy[0]), 32'd0);

    // Every word holds INIT_VALUE after the sweep.
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      check($sformatf("init_read_%0d", a), 32'(dut_dout[0]), 32'h5A);
      check($sformatf("init_valid_%0d", a), 32'(dut_rv[0]), 32'd1);
    end
    re = 1'b0;
    tick();

    // Writes then back-to-back reads.
    wr(4'd1, 8'hA5);
    wr(4'd2, 8'h3C);
    wr(4'd3, 8'h7F);
    rd(4'd1);
    check("b2b_1", 32'(dut_dout[0]), 32'hA5);
    check("b2b_1_v", 32'(dut_rv[0]), 32'd1);
    rd(4'd2);
    check("b2b_2", 32'(dut_dout[0]), 32'h3C);
    check("b2b_2_v", 32'(dut_rv[0]), 32'd1);
    rd(4'd3);
    check("b2b_3", 32'(dut_dout[0]), 32'h7F);
    check("b2b_3_v", 32'(dut_rv[0]), 32'd1);
    re = 1'b0;
    tick();
    check("re_drop_v", 32'(dut_rv[0]), 32'd0);
    check("re_drop_hold", 32'(dut_dout[0]), 32'h7F);

    // Read-during-write collision at address 4.
    wr(4'd4, 8'h11);
    we = 1'b1; re = 1'b1; wr_addr = 4'd4; rd_addr = 4'd4; d_in = 8'h22;
    tick();
    we = 1'b0;
    check("collide_wf", 32'(dut_dout[0]), 32'h22);
    check("collide_rf", 32'(dut_dout[1]), 32'h11);
    check("collide_wf_d12", 32'(dut_dout[2]), 32'h22);
    rd(4'd4);
    check("after_collide_wf", 32'(dut_dout[0]), 32'h22);
    check("after_collide_rf", 32'(dut_dout[1]), 32'h22);
    re = 1'b0;
    tick();

    // Out-of-range access on the DEPTH 12 instance.
    wr(4'd13, 8'hFF);
    rd(4'd13);
    check("oor_read", 32'(dut_dout[2]), 32'h00);
    check("oor_valid", 32'(dut_rv[2]), 32'd1);
    check("inrange_13", 32'(dut_dout[0]), 32'hFF);
    rd(4'd12);
    check("oor_read_12", 32'(dut_dout[2]), 32'h00);
    re = 1'b0;
    tick();

    // Clear wins over a same-cycle write.
    clear = 1'b1; we = 1'b1; wr_addr = 4'd5; d_in = 8'h99;
    tick();
    clear = 1'b0; we = 1'b0;
    nb = 0;
    for (int i = 0; i < 40 && dut_busy[1]; i++) begin
      nb++;
      tick();
    end
    check("clear_busy_len", 32'(nb), 32'd16);
    rd(4'd5);
    check("clear_dropped_wr", 32'(dut_dout[1]), 32'h00);
    check("clear_reinit", 32'(dut_dout[0]), 32'h5A);
    re = 1'b0;
    tick();

    // Reset asserted while the sweep counter sits at address 7.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #2;
    check("midsweep_rst_busy", 32'(dut_busy[0]), 32'd1);
    check("midsweep_rst_v", 32'(dut_rv[0]), 32'd0);
    check("midsweep_rst_dout", 32'(dut_dout[0]), 32'h00);
    tick();
    tick();
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 40 && dut_busy[0]; i++) begin
      nb++;
      tick();
    end
    check("rst_busy_len", 32'(nb), 32'd16);
    rd(4'd7);
    check("after_rst_read", 32'(dut_dout[0]), 32'h5A);
    re = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_param.md
# dual_port_ram_param

Parametrised simple dual-port RAM: one write port, one read port, one clock. Registered read data with a one-cycle `rd_valid` strobe, and a selectable read-during-write collision mode. A built-in initialisation sweep loads every word with `INIT_VALUE` after reset or on request. This is the general storage macro for buffers and register files that previously used fixed 16x8 RAMs.

## Interface
- `DATA_WIDTH`, default 8: word width in bits.
- `ADDR_WIDTH`, default 4: address width in bits.
- `DEPTH`, default 16: number of words; must satisfy 1 ≤ `DEPTH` ≤ 2^`ADDR_WIDTH`.
- `INIT_VALUE`, default 0: `DATA_WIDTH`-bit value written to every word by the sweep.
- `RD_MODE`, default 0: collision mode. 0 = write-first (new data), 1 = read-first (old data).

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  single-cycle request to re-run the init sweep.
- `we`  in  1  write enable.
- `wr_addr`  in  `ADDR_WIDTH`  write address.
- `d_in`  in  `DATA_WIDTH`  write data.
- `re`  in  1  read enable.
- `rd_addr`  in  `ADDR_WIDTH`  read address.
- `d_out`  out  `DATA_WIDTH`  registered read data.
- `rd_valid`  out  1  high for exactly one cycle when `d_out` is updated by a read.
- `busy`  out  1  high while the init sweep runs; `we`, `re` and `clear` are ignored while high.

## Operation
- Two-state FSM: INIT (sweeping) and IDLE (serving).
- Reset (`rst_n`=0, asynchronous):
  - state = INIT, sweep counter = 0.
  - `busy`=1, `d_out`=0, `rd_valid`=0.
  - Array contents are not cleared by reset itself; the sweep does that.
- INIT:
  - Each edge writes `INIT_VALUE` to the address held in the sweep counter, then increments the counter.
  - After writing address `DEPTH`-1, the FSM moves to IDLE and `busy` goes to 0 on that same edge.
  - `we`, `re` and `clear` are ignored. `rd_valid` stays 0 and `d_out` holds its value.
- IDLE, `clear`=1:
  - Counter is set to 0, state moves to INIT, and `busy` rises on the next edge.
  - A `we` or `re` in the same cycle is dropped; `clear` wins.
- IDLE, `we`=1: `mem[wr_addr]` ← `d_in`. Writes with `wr_addr` ≥ `DEPTH` are discarded.
- IDLE, `re`=1:
  - `d_out` ← `mem[rd_addr]` and `rd_valid` ← 1.
  - If `rd_addr` ≥ `DEPTH`, `d_out` ← 0 and `rd_valid` ← 1.
- IDLE, `re`=0: `rd_valid` ← 0 and `d_out` holds its last value.
- Collision (`we` and `re` both 1 with `wr_addr` == `rd_addr` < `DEPTH`):
  - `RD_MODE`=0: `d_out` ← `d_in`.
  - `RD_MODE`=1: `d_out` ← the pre-write contents.
  - The write is performed in both modes.
- Reads and writes to different addresses are independent and both complete in the same cycle.

## Timing
- Sweep timing: counting from the first rising edge with `rst_n`=1 as edge 1:
  - Edge k writes address k-1.
  - `busy` falls at edge `DEPTH`.
  - The first accepted `we`/`re` is sampled at edge `DEPTH`+1.
- Write latency: data is visible to a read sampled on the next edge (write-first mode: visible on the same edge).
- Read latency: one cycle. Inputs are sampled at edge N; `d_out` and `rd_valid` are valid after edge N. Back-to-back reads give one word per cycle with `rd_valid` held high.
- `clear` pulsed at edge N: `busy`=1 from edge N+1 through edge N+`DEPTH`.
- Reset asserted mid-sweep or mid-operation: immediate return to the reset values; the sweep restarts from address 0.
- `DEPTH`=1: `busy` falls at edge 1.

## Test plan
Defaults unless stated: `DATA_WIDTH`=8, `ADDR_WIDTH`=4, `DEPTH`=16, `RD_MODE`=0.
- Reset, then release with `INIT_VALUE`=8'h5A:
  - `busy`=1 for 16 edges and falls at edge 16.
  - Reading addresses 0..15 then returns 8'h5A each, with `rd_valid` high one cycle per read.
- Write 8'hA5, 8'h3C, 8'h7F to addresses 1, 2, 3; read them back-to-back:
  - `d_out` = A5, 3C, 7F on consecutive cycles with `rd_valid` continuously 1.
  - After `re` drops, `rd_valid`=0 and `d_out` stays 8'h7F.
- Collision at address 4 (old value 8'h11, new 8'h22):
  - `RD_MODE`=0 gives `d_out`=8'h22.
  - `RD_MODE`=1 gives `d_out`=8'h11.
  - A following read returns 8'h22 in both modes.
- `DEPTH`=12: write 8'hFF to address 13, then read 13 → `d_out`=8'h00, `rd_valid`=1; address 12 is unaffected.
- `clear` pulsed together with `we` to address 5 (8'h99), `INIT_VALUE`=0:
  - `busy`=1 for 16 cycles; the write is dropped.
  - Reading address 5 afterwards gives 8'h00.
- `rst_n` pulsed low at sweep address 7:
  - Outputs return to reset values immediately.
  - The sweep restarts and `busy` falls 16 edges after release.
